// File: rtl/alib_octree_code_streamer.sv
// Streams a snapshot of the octree occupation code as a header beat (byte count)
// followed by little-endian packed payload beats on a 32-bit AXI4-Stream master.
module alib_octree_code_streamer #(
    parameter int NUMBER_NODES = 200,
    parameter int CNT_W        = 16
) (
    input  logic                      i_SYSTEM_clk,
    input  logic                      i_SYSTEM_rst,
    input  logic                      i_dfs_done,
    input  logic [8*NUMBER_NODES-1:0] i_occupation_code,
    input  logic [31:0]               i_occupation_code_size_bytes,
    output logic [31:0]               o_m_tdata,
    output logic [3:0]                o_m_tkeep,
    output logic                      o_m_tvalid,
    input  logic                      i_m_tready,
    output logic                      o_m_tlast,
    output logic                      o_busy,
    output logic                      o_stream_done,
    output logic                      o_size_clamped,
    output logic                      o_dropped,
    output logic [1:0]                o_dbg_state
);

    // Stream handshake: a beat transfers on any rising clk edge where
    // o_m_tvalid & i_m_tready; while tvalid is high and tready low the beat
    // (tdata/tkeep/tlast) is held, and tvalid only falls after a transfer.

    localparam logic [CNT_W-1:0] MAX_BYTES    = CNT_W'(NUMBER_NODES);
    localparam logic [31:0]      MAX_BYTES_32 = 32'(NUMBER_NODES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic                      dfs_q;
    logic                      sample_seen_q;
    logic                      dfs_rise;
    logic                      capture;
    logic                      beat_accept;
    logic [8*NUMBER_NODES-1:0] snapshot_q;
    logic [CNT_W-1:0]          size_q;
    logic [CNT_W-1:0]          byte_idx_q;
    logic [CNT_W-1:0]          remaining;
    logic                      clamped_q;
    logic                      dropped_q;
    logic [3:0]                lane_keep;
    logic [31:0]               lane_data;

    // dfs_q resets to 0, so an input already high at reset release would look
    // like a rising edge; sample_seen_q blocks that until one real sample exists.
    assign dfs_rise    = i_dfs_done & ~dfs_q & sample_seen_q;
    assign capture     = (state_q == ST_IDLE) & dfs_rise;
    assign beat_accept = o_m_tvalid & i_m_tready;
    assign remaining   = size_q - byte_idx_q;

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            dfs_q         <= 1'b0;
            sample_seen_q <= 1'b0;
        end else begin
            dfs_q         <= i_dfs_done;
            sample_seen_q <= 1'b1;
        end
    end

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The snapshot shifts down one word per payload beat, so the current beat
    // always sits in the low 32 bits.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            snapshot_q <= '0;
            size_q     <= '0;
            byte_idx_q <= '0;
            clamped_q  <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            dropped_q <= dfs_rise & (state_q != ST_IDLE);
            if (capture) begin
                snapshot_q <= i_occupation_code;
                byte_idx_q <= '0;
                if (i_occupation_code_size_bytes > MAX_BYTES_32) begin
                    size_q    <= MAX_BYTES;
                    clamped_q <= 1'b1;
                end else begin
                    size_q <= i_occupation_code_size_bytes[CNT_W-1:0];
                end
            end else if ((state_q == ST_PAYLOAD) && beat_accept) begin
                snapshot_q <= snapshot_q >> 32;
                byte_idx_q <= byte_idx_q + CNT_W'(4);
            end
        end
    end

    always_comb begin
        lane_keep = '0;
        lane_data = '0;
        for (int j = 0; j < 4; j++) begin
            lane_keep[j]        = remaining > CNT_W'(j);
            lane_data[8*j +: 8] = lane_keep[j] ? snapshot_q[8*j +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_d       = state_q;
        o_m_tvalid    = 1'b0;
        o_m_tdata     = '0;
        o_m_tkeep     = '0;
        o_m_tlast     = 1'b0;
        o_busy        = 1'b0;
        o_stream_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dfs_rise) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                o_m_tvalid = 1'b1;
                o_m_tdata  = 32'(size_q);
                o_m_tkeep  = 4'b1111;
                o_m_tlast  = (size_q == '0);
                o_busy     = 1'b1;
                if (i_m_tready) state_d = (size_q == '0) ? ST_DONE : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                o_m_tvalid = 1'b1;
                o_m_tdata  = lane_data;
                o_m_tkeep  = lane_keep;
                o_m_tlast  = (remaining <= CNT_W'(4));
                o_busy     = 1'b1;
                if (i_m_tready && o_m_tlast) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_stream_done = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_size_clamped = clamped_q;
    assign o_dropped      = dropped_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_alib_octree_code_streamer.sv
// Bench for alib_octree_code_streamer: directed packets with literal beat checks,
// then randomized packets, stalls and re-triggers against a packet-level model.
module tb_alib_octree_code_streamer;

    localparam int NN = 200;

    logic            clk;
    logic            rst_n;
    logic            dfs_done;
    logic [8*NN-1:0] code_bus;
    logic [31:0]     code_size;
    logic            tready;
    logic [31:0]     tdata;
    logic [3:0]      tkeep;
    logic            tvalid;
    logic            tlast;
    logic            busy;
    logic            stream_done;
    logic            size_clamped;
    logic            dropped;
    logic [1:0]      dbg_state;

    alib_octree_code_streamer #(.NUMBER_NODES(NN), .CNT_W(16)) dut (
        .i_SYSTEM_clk                 (clk),
        .i_SYSTEM_rst                 (rst_n),
        .i_dfs_done                   (dfs_done),
        .i_occupation_code            (code_bus),
        .i_occupation_code_size_bytes (code_size),
        .o_m_tdata                    (tdata),
        .o_m_tkeep                    (tkeep),
        .o_m_tvalid                   (tvalid),
        .i_m_tready                   (tready),
        .o_m_tlast                    (tlast),
        .o_busy                       (busy),
        .o_stream_done                (stream_done),
        .o_size_clamped               (size_clamped),
        .o_dropped                    (dropped),
        .o_dbg_state                  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    // Entry layout: {tlast, tkeep[3:0], tdata[31:0]}
    logic [36:0] exp_q[$];
    logic [36:0] got_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          drop_cnt = 0;
    int          ready_mode = 0;
    bit          done_pend = 0;
    bit          drop_pend = 0;
    bit          clamp_m = 0;
    bit          m_prev_low = 0;
    bit          m_idle;
    bit          m_rise;
    bit          m_new_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet as the sink must see it: header with clamped size, then bytes
    // packed four per beat, lane 0 first, unused lanes zero with keep low.
    task automatic build_packet(input logic [31:0] sz);
        int          n;
        logic [31:0] d;
        logic [3:0]  kp;
        n = (sz > 32'(NN)) ? NN : int'(sz);
        if (sz > 32'(NN)) clamp_m = 1'b1;
        exp_q.push_back({(n == 0), 4'hf, 32'(n)});
        for (int b = 0; b < n; b += 4) begin
            d  = '0;
            kp = '0;
            for (int j = 0; j < 4; j++) begin
                if (b + j < n) begin
                    d[8*j +: 8] = code_bus[8*(b+j) +: 8];
                    kp[j]       = 1'b1;
                end
            end
            exp_q.push_back({(b + 4 >= n), kp, d});
        end
    endtask

    // Compare outputs of the current cycle, then advance the model across the
    // coming clock edge using the inputs that edge will sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs",
                  {tvalid, tdata, tkeep, tlast, busy, stream_done, size_clamped, dropped}, '0);
            exp_q.delete();
            done_pend  = 0;
            drop_pend  = 0;
            clamp_m    = 0;
            m_prev_low = 0;
        end else begin
            if (exp_q.size() != 0) check("beat", {tvalid, tlast, tkeep, tdata}, {1'b1, exp_q[0]});
            else                   check("tvalid_idle", tvalid, 0);
            check("busy", busy, exp_q.size() != 0);
            check("stream_done", stream_done, done_pend);
            check("dropped", dropped, drop_pend);
            check("size_clamped", size_clamped, clamp_m);
            if (dropped) drop_cnt++;

            m_idle     = (exp_q.size() == 0) && !done_pend;
            m_new_done = 0;
            if (exp_q.size() != 0 && tready) begin
                got_q.push_back({tlast, tkeep, tdata});
                m_new_done = exp_q[0][36];
                exp_q.delete(0);
            end
            m_rise     = dfs_done && m_prev_low;
            m_prev_low = !dfs_done;
            drop_pend  = m_rise && !m_idle;
            if (m_rise && m_idle) build_packet(code_size);
            done_pend = m_new_done;
        end
    end

    // ---------------- driver tasks ----------------
    initial begin
        int ph;
        ph = 0;
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tready = 1'b1;
                1: begin tready = (ph % 3 == 0); ph++; end
                default: tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic scramble_inputs();
        for (int k = 0; k < NN / 4; k++) code_bus[32*k +: 32] = $urandom();
        code_size = $urandom_range(0, 300);
    endtask

    task automatic set_seq_bytes();
        code_bus = '0;
        for (int k = 0; k < NN; k++) code_bus[8*k +: 8] = 8'(k + 1);
    endtask

    task automatic fire(input logic [31:0] sz, input bit keep_high);
        @(posedge clk);
        #1;
        code_size = sz;
        dfs_done  = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_high) dfs_done = 1'b0;
    endtask

    // Inputs are scrambled every cycle while waiting, so a packet in flight
    // must come only from its snapshot.
    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || done_pend) && k < budget) begin
            @(posedge clk);
            #1;
            scramble_inputs();
            k++;
        end
        check("wait_idle_timeout", k >= budget, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string nm, input int idx, input logic [31:0] d,
                              input logic [3:0] kp, input logic l);
        check(nm, (got_q.size() > idx) ? {1'b0, got_q[idx]} : {1'b1, 37'h0}, {1'b0, l, kp, d});
    endtask

    task automatic check_size10_packet(input string tag);
        check({tag, "_beats"}, got_q.size(), 4);
        check_beat({tag, "_hdr"}, 0, 32'h0000000A, 4'b1111, 1'b0);
        check_beat({tag, "_p0"},  1, 32'h04030201, 4'b1111, 1'b0);
        check_beat({tag, "_p1"},  2, 32'h08070605, 4'b1111, 1'b0);
        check_beat({tag, "_p2"},  3, 32'h00000A09, 4'b0011, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        logic [31:0] sz;
        logic [31:0] bnd[8];
        bnd = '{32'd1, 32'd3, 32'd4, 32'd5, 32'd199, 32'd200, 32'd201, 32'hFFFF_FFFF};

        rst_n     = 1'b0;
        dfs_done  = 1'b0;
        code_bus  = '0;
        code_size = '0;
        #1;
        check("reset_state", {tvalid, busy, stream_done, size_clamped, dropped}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Size 10, tready always high
        set_seq_bytes();
        got_q.delete();
        ready_mode = 0;
        fire(32'd10, 0);
        @(negedge clk);
        check("hdr_latency", {tvalid, tdata}, {1'b1, 32'h0000000A});
        wait_idle(200);
        check_size10_packet("t1");

        // Same packet with tready 1,0,0 repeating
        set_seq_bytes();
        got_q.delete();
        ready_mode = 1;
        fire(32'd10, 0);
        wait_idle(200);
        check_size10_packet("t2");

        // Empty packet
        got_q.delete();
        ready_mode = 0;
        fire(32'd0, 0);
        wait_idle(50);
        check("t3_beats", got_q.size(), 1);
        check_beat("t3_hdr", 0, 32'h0, 4'b1111, 1'b1);

        // Oversized request clamps to NUMBER_NODES
        set_seq_bytes();
        got_q.delete();
        fire(32'd250, 0);
        wait_idle(400);
        check("t4_beats", got_q.size(), 51);
        check_beat("t4_hdr", 0, 32'h000000C8, 4'b1111, 1'b0);
        check_beat("t4_last", 50, 32'hC8C7C6C5, 4'b1111, 1'b1);
        check("t4_clamped", size_clamped, 1);

        // Second rising edge while streaming is dropped
        set_seq_bytes();
        got_q.delete();
        drop_cnt = 0;
        fire(32'd100, 0);
        repeat (5) @(posedge clk);
        #1;
        dfs_done = 1'b1;
        @(posedge clk);
        #1;
        dfs_done = 1'b0;
        wait_idle(400);
        check("t5_drop_count", drop_cnt, 1);
        check("t5_beats", got_q.size(), 26);
        check("t5_clamped_sticky", size_clamped, 1);

        // Reset during the second payload beat with dfs_done held high
        set_seq_bytes();
        got_q.delete();
        fire(32'd10, 1);
        k = 0;
        while (got_q.size() < 2 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t6_reach_beat2", k >= 50, 0);
        rst_n = 1'b0;
        #1;
        check("t6_async_clear",
              {tvalid, tdata, tkeep, tlast, busy, stream_done, size_clamped, dropped}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        repeat (8) @(posedge clk);
        #1;
        check("t6_no_packet_while_high", got_q.size(), 0);
        dfs_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_seq_bytes();
        fire(32'd10, 0);
        wait_idle(200);
        check_size10_packet("t6");

        // Boundary sizes, then random sizes, stalls and stray re-triggers
        for (int i = 0; i < 24; i++) begin
            scramble_inputs();
            sz = (i < 8) ? bnd[i] : 32'($urandom_range(0, 260));
            ready_mode = $urandom_range(0, 2);
            fire(sz, 0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 6)) begin
                    @(posedge clk);
                    #1;
                end
                dfs_done = 1'b1;
                @(posedge clk);
                #1;
                dfs_done = 1'b0;
            end
            wait_idle(1500);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
